// File: rtl/fft_r2_butterfly_stage.sv
// Radix-2 DIF butterfly with per-stage twiddle ROM: y0=(x0+x1)/2, y1=((x0-x1)/2)*W(j).
// Latency 3 enabled cycles, one pair per cycle; enable=0 stalls everything, no backpressure.
// No ready handshake: enable freezes all state including the twiddle counter.
module fft_r2_butterfly_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int N          = 8,
    parameter int STAGE      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] x0_re,
    input  logic [DATA_WIDTH-1:0] x0_im,
    input  logic [DATA_WIDTH-1:0] x1_re,
    input  logic [DATA_WIDTH-1:0] x1_im,
    output logic [DATA_WIDTH-1:0] y0_re,
    output logic [DATA_WIDTH-1:0] y0_im,
    output logic [DATA_WIDTH-1:0] y1_re,
    output logic [DATA_WIDTH-1:0] y1_im,
    output logic                  out_valid,
    output logic                  group_last
);
    localparam int DW = DATA_WIDTH;
    localparam int TW = TW_WIDTH;
    localparam int M  = N >> (STAGE + 1);
    localparam int JW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = DW + TW;
    localparam int AW = PW + 2;

    localparam longint PI_Q30  = 64'sd3373259426;
    localparam longint ONE_Q30 = 64'sd1073741824;
    localparam longint TW_MAX  = (longint'(1) <<< (TW - 1)) - 1;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [AW-1:0] RND     = {{(AW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};

    // Fixed-point Taylor series (Q30), angle folded into [0, pi/2] so it converges fast.
    function automatic logic [TW-1:0] tw_value(input int idx, input logic want_im);
        longint k;
        longint ang;
        longint xsq;
        longint term;
        longint acc;
        longint q;
        logic   fold;
        k    = longint'(idx) <<< STAGE;
        fold = (4 * k > longint'(N));
        if (fold) begin
            k = longint'(N) / 2 - k;
        end
        ang  = (PI_Q30 * 2 * k) / longint'(N);
        xsq  = (ang * ang) >>> 30;
        acc  = want_im ? ang : ONE_Q30;
        term = acc;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * xsq) >>> 30);
            if (want_im) begin
                term = term / longint'((2 * n) * (2 * n + 1));
            end else begin
                term = term / longint'((2 * n - 1) * (2 * n));
            end
            acc = acc + term;
        end
        q = (acc + (longint'(1) <<< (30 - TW))) >>> (31 - TW);
        if (q > TW_MAX) begin
            q = TW_MAX;
        end
        // Imag part is -sin; real part flips sign past pi/2.
        if (want_im || fold) begin
            q = -q;
        end
        return q[TW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
        logic [DW-1:0] r;
        if (v > SAT_MAX) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    logic [TW-1:0] rom_re [M];
    logic [TW-1:0] rom_im [M];

    for (genvar g = 0; g < M; g++) begin : g_rom
        localparam logic [TW-1:0] RE = tw_value(g, 1'b0);
        localparam logic [TW-1:0] IM = tw_value(g, 1'b1);
        assign rom_re[g] = RE;
        assign rom_im[g] = IM;
    end

    logic [JW-1:0] j;
    logic          j_last;
    assign j_last = (j == JW'(M - 1));

    // One guard bit so the half-sum/difference can never wrap before the shift.
    logic [DW:0] sum_re, sum_im, dif_re, dif_im;
    assign sum_re = {x0_re[DW-1], x0_re} + {x1_re[DW-1], x1_re};
    assign sum_im = {x0_im[DW-1], x0_im} + {x1_im[DW-1], x1_im};
    assign dif_re = {x0_re[DW-1], x0_re} - {x1_re[DW-1], x1_re};
    assign dif_im = {x0_im[DW-1], x0_im} - {x1_im[DW-1], x1_im};

    logic unused_lsb;
    assign unused_lsb = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

    logic [DW-1:0] s1_re, s1_im, d1_re, d1_im;
    logic [TW-1:0] w_re, w_im;
    logic          v1, l1;

    logic [DW-1:0]        s2_re, s2_im;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 v2, l2;

    logic signed [AW-1:0] acc_re, acc_im, rnd_re, rnd_im;
    assign acc_re = AW'(p_rr) - AW'(p_ii) + RND;
    assign acc_im = AW'(p_ri) + AW'(p_ir) + RND;
    assign rnd_re = acc_re >>> (TW - 1);
    assign rnd_im = acc_im >>> (TW - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            j          <= '0;
            s1_re      <= '0;
            s1_im      <= '0;
            d1_re      <= '0;
            d1_im      <= '0;
            w_re       <= '0;
            w_im       <= '0;
            v1         <= 1'b0;
            l1         <= 1'b0;
            s2_re      <= '0;
            s2_im      <= '0;
            p_rr       <= '0;
            p_ii       <= '0;
            p_ri       <= '0;
            p_ir       <= '0;
            v2         <= 1'b0;
            l2         <= 1'b0;
            y0_re      <= '0;
            y0_im      <= '0;
            y1_re      <= '0;
            y1_im      <= '0;
            out_valid  <= 1'b0;
            group_last <= 1'b0;
        end else if (enable) begin
            if (in_valid) begin
                j <= j_last ? '0 : j + 1'b1;
            end
            s1_re <= sum_re[DW:1];
            s1_im <= sum_im[DW:1];
            d1_re <= dif_re[DW:1];
            d1_im <= dif_im[DW:1];
            w_re  <= rom_re[j];
            w_im  <= rom_im[j];
            v1    <= in_valid;
            l1    <= in_valid & j_last;

            s2_re <= s1_re;
            s2_im <= s1_im;
            p_rr  <= PW'($signed(d1_re)) * PW'($signed(w_re));
            p_ii  <= PW'($signed(d1_im)) * PW'($signed(w_im));
            p_ri  <= PW'($signed(d1_re)) * PW'($signed(w_im));
            p_ir  <= PW'($signed(d1_im)) * PW'($signed(w_re));
            v2    <= v1;
            l2    <= l1;

            y0_re      <= s2_re;
            y0_im      <= s2_im;
            y1_re      <= sat(rnd_re);
            y1_im      <= sat(rnd_im);
            out_valid  <= v2;
            group_last <= l2;
        end
    end
endmodule
